// File: rtl/hex_scan_if.sv
// hex_scan_if: processor write handshake and display drive bundle for hex_scan_ctrl.
//   wr_en    write strobe, accepted only while ready is high
//   wr_data  4*NDIG-bit value, nibble k drives digit k (digit 0 least significant)
//   ready    high when a write can be accepted (no commit pending)
//   seg_out  active-low segments {g,f,e,d,c,b,a}
//   an_out   active-low digit enables, at most one bit low
interface hex_scan_if #(
    parameter int unsigned NDIG = 4
);
    logic                  wr_en;
    logic [4*NDIG-1:0]     wr_data;
    logic                  ready;
    logic [6:0]            seg_out;
    logic [NDIG-1:0]       an_out;

    modport master (
        output wr_en,
        output wr_data,
        input  ready,
        input  seg_out,
        input  an_out
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output ready,
        output seg_out,
        output an_out
    );
endinterface

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: time-multiplexed, double-buffered hex driver for NDIG common-anode
// 7-segment digits sharing one segment bus, with an all-off gap between digits.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    hex_scan_if slave: wr_en/wr_data in, ready/seg_out/an_out out (all registered)
// Optional: define HEX_SCAN_LZ_BLANK_EN for leading-zero blanking (digit 0 never blanked).
module hex_scan_ctrl #(
    parameter int unsigned NDIG    = 4,
    parameter int unsigned DIV     = 50000,
    parameter int unsigned GAP_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    hex_scan_if.slave  bus
);

    localparam int unsigned IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned CNT_MAX = (DIV > GAP_CYC) ? DIV : GAP_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   first_q, first_d;
    logic [NDIG-1:0][3:0]   active_q, active_d;
    logic [NDIG-1:0][3:0]   shadow_q, shadow_d;
    logic                   pending_q, pending_d;
    logic                   ready_q, ready_d;
    logic [6:0]             seg_q, seg_d;
    logic [NDIG-1:0]        an_q, an_d;
    logic                   commit;
    logic                   blank;

    // Active-low hex glyphs, bits 6..0 = {g,f,e,d,c,b,a}
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h7F;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

`ifdef HEX_SCAN_LZ_BLANK_EN
    // Blank the current digit when it and every more-significant nibble are zero
    always_comb begin
        blank = (idx_q != '0);
        for (int unsigned j = 0; j < NDIG; j++) begin
            if (IDX_W'(j) >= idx_q && active_q[IDX_W'(j)] != 4'h0) begin
                blank = 1'b0;
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Scan sequencing, frame commit, write handshake and output decode
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        commit    = 1'b0;
        an_d      = '1;
        seg_d     = 7'h7F;

        case (state_q)
            ST_SHOW: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SHOW;
                    first_d = 1'b0;
                    // The gap right after reset leads into digit 0 without advancing
                    if (!first_q) begin
                        idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;
                    end
                    commit = (idx_d == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        // A commit with a pending value wins; ready is low then, so no write can collide
        if (commit && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (bus.wr_en && ready_q) begin
            shadow_d  = bus.wr_data;
            pending_d = 1'b1;
        end
        ready_d = !pending_d;

        if (state_q == ST_SHOW) begin
            an_d[idx_q] = 1'b0;
            if (!blank) begin
                seg_d = enc(active_q[idx_q]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_GAP;
            idx_q     <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b1;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            seg_q     <= 7'h7F;
            an_q      <= '1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.seg_out = seg_q;
    assign bus.an_out  = an_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: directed bench for hex_scan_ctrl with NDIG=4, DIV=4, GAP_CYC=1.
module tb_hex_scan_ctrl;

    localparam int unsigned NDIG    = 4;
    localparam int unsigned DIV     = 4;
    localparam int unsigned GAP_CYC = 1;
    localparam int          FRAME   = 20;

    localparam logic [6:0] S_0 = 7'b1000000;
    localparam logic [6:0] S_1 = 7'b1111001;
    localparam logic [6:0] S_2 = 7'b0100100;
    localparam logic [6:0] S_3 = 7'b0110000;
    localparam logic [6:0] S_4 = 7'b0011001;
    localparam logic [6:0] S_5 = 7'b0010010;
    localparam logic [6:0] S_A = 7'b0001000;
    localparam logic [6:0] S_C = 7'b1000110;
    localparam logic [6:0] S_D = 7'b0100001;
    localparam logic [6:0] S_E = 7'b0000110;
    localparam logic [6:0] S_F = 7'b0001110;
`ifdef HEX_SCAN_LZ_BLANK_EN
    localparam logic [6:0] S_LZ = 7'h7F;
`else
    localparam logic [6:0] S_LZ = 7'b1000000;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hex_scan_if #(.NDIG(NDIG)) bus ();

    hex_scan_ctrl #(
        .NDIG    (NDIG),
        .DIV     (DIV),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] cap_an  [FRAME];
    logic [6:0] cap_seg [FRAME];

    // Expected digit enables at sample p of a frame: 4 lit samples then 1 all-off
    function automatic logic [3:0] exp_an(input int p);
        logic [3:0] one;
        one = 4'b0001;
        if (p % 5 == 4) return 4'hF;
        return ~(one << (p / 5));
    endfunction

    // Advance to the first sample of a frame (digit 0 lit right after an all-off sample)
    task automatic sync_frame();
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev  = bus.an_out;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (prev == 4'hF && bus.an_out == 4'hE) found = 1'b1;
            else prev = bus.an_out;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL sync_frame: no frame start seen within 200 cycles, an_out=%b", bus.an_out);
        end
    endtask

    // Record 20 samples starting with the current one
    task automatic capture_frame();
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            cap_an[i]  = bus.an_out;
            cap_seg[i] = bus.seg_out;
        end
    endtask

    task automatic test_reset();
        logic [6:0] digs [4];
        logic [6:0] es;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.seg_out !== 7'h7F || bus.an_out !== 4'hF || bus.ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hold: seg=%h an=%b ready=%b, want seg=7f an=1111 ready=1",
                     bus.seg_out, bus.an_out, bus.ready);
        end
        rst_n = 1'b1;
        sync_frame();
        bus.wr_data = 16'h9999;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        n_vec++;
        if (bus.ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pre_write_ready: ready=%b, want 0", bus.ready);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.seg_out !== 7'h7F || bus.an_out !== 4'hF || bus.ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_show: seg=%h an=%b ready=%b, want seg=7f an=1111 ready=1",
                     bus.seg_out, bus.an_out, bus.ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.seg_out !== 7'h7F || bus.an_out !== 4'hF) begin
            n_err++;
            $display("FAIL reset_first_gap: seg=%h an=%b, want seg=7f an=1111", bus.seg_out, bus.an_out);
        end
        @(negedge clk);
        capture_frame();
        digs = '{S_0, S_LZ, S_LZ, S_LZ};
        for (int p = 0; p < FRAME; p++) begin
            es = (p % 5 == 4) ? 7'h7F : digs[p / 5];
            n_vec++;
            if (cap_an[p] !== exp_an(p) || cap_seg[p] !== es) begin
                n_err++;
                $display("FAIL reset_first_frame p%0d: an=%b seg=%b, want an=%b seg=%b",
                         p, cap_an[p], cap_seg[p], exp_an(p), es);
            end
        end
    endtask

    task automatic test_write_commit();
        logic [6:0] digs [4];
        logic [6:0] es;
        logic       er;
        sync_frame();
        bus.wr_data = 16'h1A3F;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        for (int s = 1; s < FRAME; s++) begin
            if (s > 1) @(negedge clk);
            er = (s == FRAME - 1);
            n_vec++;
            if (bus.ready !== er) begin
                n_err++;
                $display("FAIL commit_ready s%0d: ready=%b, want %b", s, bus.ready, er);
            end
        end
        @(negedge clk);
        capture_frame();
        digs = '{S_F, S_3, S_A, S_1};
        for (int p = 0; p < FRAME; p++) begin
            es = (p % 5 == 4) ? 7'h7F : digs[p / 5];
            n_vec++;
            if (cap_an[p] !== exp_an(p) || cap_seg[p] !== es) begin
                n_err++;
                $display("FAIL commit_1A3F p%0d: an=%b seg=%b, want an=%b seg=%b",
                         p, cap_an[p], cap_seg[p], exp_an(p), es);
            end
        end
    endtask

    task automatic test_write_pending();
        logic [6:0] digs [4];
        logic [6:0] es;
        digs = '{S_4, S_3, S_2, S_1};
        sync_frame();
        bus.wr_data = 16'h1234;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.ready !== 1'b0) begin
            n_err++;
            $display("FAIL pending_ready: ready=%b, want 0", bus.ready);
        end
        bus.wr_data = 16'h5678;
        @(negedge clk);
        bus.wr_en = 1'b0;
        repeat (17) @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            capture_frame();
            for (int p = 0; p < FRAME; p++) begin
                es = (p % 5 == 4) ? 7'h7F : digs[p / 5];
                n_vec++;
                if (cap_an[p] !== exp_an(p) || cap_seg[p] !== es) begin
                    n_err++;
                    $display("FAIL pending_1234 f%0d p%0d: an=%b seg=%b, want an=%b seg=%b",
                             f, p, cap_an[p], cap_seg[p], exp_an(p), es);
                end
            end
            n_vec++;
            if (bus.ready !== 1'b1) begin
                n_err++;
                $display("FAIL pending_ready_after f%0d: ready=%b, want 1", f, bus.ready);
            end
        end
    endtask

    task automatic test_write_on_commit();
        logic [6:0] old_digs [4];
        logic [6:0] new_digs [4];
        logic [6:0] es;
        old_digs = '{S_4, S_3, S_2, S_1};
        new_digs = '{S_E, S_D, S_0, S_C};
        sync_frame();
        repeat (18) @(negedge clk);
        bus.wr_data = 16'hC0DE;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        n_vec++;
        if (bus.ready !== 1'b0) begin
            n_err++;
            $display("FAIL oncommit_accept: ready=%b, want 0", bus.ready);
        end
        @(negedge clk);
        capture_frame();
        for (int p = 0; p < FRAME; p++) begin
            es = (p % 5 == 4) ? 7'h7F : old_digs[p / 5];
            n_vec++;
            if (cap_an[p] !== exp_an(p) || cap_seg[p] !== es) begin
                n_err++;
                $display("FAIL oncommit_old p%0d: an=%b seg=%b, want an=%b seg=%b",
                         p, cap_an[p], cap_seg[p], exp_an(p), es);
            end
        end
        n_vec++;
        if (bus.ready !== 1'b1) begin
            n_err++;
            $display("FAIL oncommit_ready: ready=%b, want 1", bus.ready);
        end
        @(negedge clk);
        capture_frame();
        for (int p = 0; p < FRAME; p++) begin
            es = (p % 5 == 4) ? 7'h7F : new_digs[p / 5];
            n_vec++;
            if (cap_an[p] !== exp_an(p) || cap_seg[p] !== es) begin
                n_err++;
                $display("FAIL oncommit_C0DE p%0d: an=%b seg=%b, want an=%b seg=%b",
                         p, cap_an[p], cap_seg[p], exp_an(p), es);
            end
        end
    endtask

    task automatic test_ghosting();
        logic [3:0] a;
        logic [3:0] prev;
        int starts [$];
        sync_frame();
        prev = 4'hF;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i > 0) @(negedge clk);
            a = bus.an_out;
            n_vec++;
            if ($countones(~a) > 1 || a !== exp_an(i % FRAME)) begin
                n_err++;
                $display("FAIL ghost_an i%0d: an=%b, want %b (at most one low)", i, a, exp_an(i % FRAME));
            end
            n_vec++;
            if (prev != 4'hF && a != 4'hF && prev != a) begin
                n_err++;
                $display("FAIL ghost_gap i%0d: an went %b -> %b, want an all-off sample between", i, prev, a);
            end
            if (prev == 4'hF && a == 4'hE) starts.push_back(i);
            prev = a;
        end
        n_vec++;
        if (starts.size() != 3) begin
            n_err++;
            $display("FAIL ghost_frames: %0d frame starts, want 3", starts.size());
        end
        for (int k = 1; k < starts.size(); k++) begin
            n_vec++;
            if (starts[k] - starts[k-1] != FRAME) begin
                n_err++;
                $display("FAIL ghost_period k%0d: %0d cycles, want %0d", k, starts[k] - starts[k-1], FRAME);
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [6:0] digs [4];
        logic [6:0] es;
        digs = '{S_0, S_5, S_LZ, S_LZ};
        sync_frame();
        bus.wr_data = 16'h0050;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        repeat (18) @(negedge clk);
        @(negedge clk);
        capture_frame();
        for (int p = 0; p < FRAME; p++) begin
            es = (p % 5 == 4) ? 7'h7F : digs[p / 5];
            n_vec++;
            if (cap_an[p] !== exp_an(p) || cap_seg[p] !== es) begin
                n_err++;
                $display("FAIL lz_0050 p%0d: an=%b seg=%b, want an=%b seg=%b",
                         p, cap_an[p], cap_seg[p], exp_an(p), es);
            end
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        test_reset();
        test_write_commit();
        test_write_pending();
        test_write_on_commit();
        test_ghosting();
        test_lz_blank();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Time-multiplexed controller for a bank of NDIG common-anode 7-segment digits that share one segment bus.
- Holds a hex value written by the processor. Scans the digits one at a time, with a ghosting-guard gap between digits.
- Decodes each nibble to an active-low segment pattern using the team's hex encoding.
- Uses double buffering: new values are committed only at frame boundaries, so the display never tears.

Parameters:
- NDIG, 4, number of digits scanned (2..8).
- DIV, 50000, clk cycles each digit is lit (>=2).
- GAP_CYC, 16, clk cycles with all digits off between digits (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe. Accepted only when ready=1.
- wr_data  input  4*NDIG  value to display. Nibble k drives digit k; digit 0 is the least significant.
- ready  output  1  high when a write can be accepted (no commit pending).
- seg_out  output  7  active-low segments {g,f,e,d,c,b,a} = bits 6..0.
- an_out  output  NDIG  active-low digit enables. At most one bit is low.

Behaviour:
- Reset state (async, rst_n=0):
  - state=GAP, idx=0, cnt=0.
  - active=0, shadow=0, pending=0, ready=1.
  - seg_out=7'h7F, an_out all ones.
- seg_out and an_out are registered. They reflect the state of the previous cycle (1-cycle latency).
- State SHOW:
  - an_out[idx]=0, seg_out=enc(active[4*idx+:4]).
  - cnt counts 0..DIV-1. At DIV-1: cnt<=0, go to GAP.
- State GAP:
  - an_out all ones, seg_out=7'h7F.
  - cnt counts 0..GAP_CYC-1. At GAP_CYC-1: cnt<=0, go to SHOW.
  - On that same transition, idx<=(idx==NDIG-1)?0:idx+1. The exception is the first GAP after reset, which keeps idx=0.
- Frame commit:
  - On the GAP->SHOW transition where the next idx is 0, if pending=1: active<=shadow, pending<=0.
  - The commit decision uses the registered pending value.
- Write handshake:
  - wr_en && ready: shadow<=wr_data, pending<=1. ready drops the next cycle.
  - wr_en && !ready: ignored, with no side effects.
  - Write and commit in the same cycle with pending=0: the write is accepted and committed at the next frame boundary, not this one.
  - Commit cycle with pending=1 and wr_en=1: the old shadow is committed and the write is ignored.
- Encoding enc(d), active-low, bits 6..0:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Frame period: NDIG*(DIV+GAP_CYC) cycles. There is no back-to-back digit overlap: a GAP always separates two SHOW states.
- Reset mid-frame returns to the reset state immediately. A pending write is discarded.

Optional Feature:
- Macro: HEX_SCAN_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit k is blanked (seg_out=7'h7F, an_out[k] still low) when active[4*j+:4]==0 for every j>=k.
  - Digit 0 is never blanked. A value of 0 shows a single "0".
- Undefined: all NDIG digits always display their nibble, including leading zeros.

Test Plan (NDIG=4, DIV=4, GAP_CYC=1):
1. Reset check.
   - Stimulus: assert rst_n=0 mid-SHOW.
   - Required response: seg_out=7F, an_out=1111, and ready=1 in the same cycle. After release, the first SHOW has an_out=1110, seg_out=1000000.
2. Write and commit.
   - Stimulus: write 16'h1A3F during frame.
   - Required response: ready=0 until the next idx-0 commit, then ready=1. Digits 0..3 show 0001110, 0110000, 0001000, 1111001. Each digit is lit 4 cycles, followed by 1 cycle all-off.
3. Write while pending.
   - Stimulus: write 16'h1234, then 16'h5678 while ready=0.
   - Required response: the second write is ignored. The display shows 1234 after commit.
4. Write on commit cycle.
   - Stimulus: wr_en coincides with the commit cycle, pending=0.
   - Required response: the value is not shown this frame. It appears after the next frame boundary.
5. Ghosting guard.
   - Stimulus: monitor an_out over 3 frames.
   - Required response: no more than one bit low at any time. A 1-cycle all-ones gap occurs between every digit. The frame period is 20 cycles.
6. Leading-zero blanking (HEX_SCAN_LZ_BLANK_EN defined).
   - Stimulus: write 16'h0050.
   - Required response: digits 3 and 2 give seg_out=7F. Digit 1 shows 0010010. Digit 0 shows 1000000.
   - Without the macro: digits 3 and 2 show 1000000.
